acc_cmd_endpoint: RTL
=====================

// Module: acc_cmd_endpoint
// PURPOSE
// - Accelerator-side endpoint of the manager command protocol; one instance per accelerator.
// - Receives execute-task commands from the manager's cmdin stream.
// - Streams task arguments to the accelerator core, then waits for core completion.
// - Returns a finish command on the manager's cmdout stream, tagged with the accelerator id.
// PARAMETERS
// - ACC_BITS   4  width of accelerator id / tid.
// - ACC_ID     0  this accelerator's id, driven on cmd_out_tid.
// - ARG_CNT_W  8  width of the argument counter (max args = 2**ARG_CNT_W-1).
// PORTS
// - clk            in   1         clock.
// - rst            in   1         asynchronous reset, active-high.
// - cmd_in_tvalid  in   1         cmdin stream from manager.
// - cmd_in_tready  out  1
// - cmd_in_tdata   in   64
// - cmd_in_tlast   in   1         marks last word of a command.
// - arg_tvalid     out  1         argument stream to core.
// - arg_tready     in   1
// - arg_tdata      out  64
// - arg_tlast      out  1
// - task_start     out  1         1-cycle pulse: task header accepted.
// - task_id        out  64        current task id; held until finish is sent.
// - done_valid     in   1         core completion handshake.
// - done_ready     out  1
// - cmd_out_tvalid out  1         cmdout stream to manager.
// - cmd_out_tready in   1
// - cmd_out_tid    out  ACC_BITS  constant ACC_ID.
// - cmd_out_tdata  out  64
// - proto_err      out  1         1-cycle pulse on a protocol error.
// BEHAVIOUR
// - Input word order: W0 header {tdata[7:0]=code, tdata[15:8]=nargs}; W1 task id; W2 parent id; then nargs args.
// - tlast must be set on the final input word only.
// - Reset: state=IDLE. All valid/ready/pulse outputs 0; task_id=0; counters 0.
// - IDLE: cmd_in_tready=1.
//   - Code 0x01 with tlast=0: go TID.
//   - Any other code: proto_err, go DRAIN; if that word has tlast=1, stay IDLE instead.
// - TID: accept W1 into task_id, go PTID.
// - PTID: accept W2 into parent register.
//   - nargs=0 requires tlast=1 here.
//   - On accept: task_start=1 next cycle; go ARGS if nargs>0, else RUN.
// - ARGS: combinational pass-through.
//   - arg_tvalid=cmd_in_tvalid, cmd_in_tready=arg_tready, arg_tdata=cmd_in_tdata.
//   - arg_tlast=1 when remaining==1. Counter decrements on each handshake.
//   - Last arg without tlast: proto_err, go DRAIN.
// - Early tlast (in TID, PTID, or ARGS before the count expires): proto_err, abort to IDLE; no task_start, no finish.
//   - Early tlast in ARGS emits the word with arg_tlast=1.
// - RUN: cmd_in_tready=0, done_ready=1. done handshake: go FIN0.
// - FIN0..FIN2: cmd_out_tvalid=1, tdata = {56'h0, 8'h03}, task_id, parent id.
//   - Advance only on cmd_out_tready. tdata/tvalid stable while stalled.
//   - After FIN2 handshake: go IDLE.
// - DRAIN: cmd_in_tready=1, discard words; tlast: go IDLE.
// - done_valid outside RUN is ignored (done_ready=0).
// - Next command's header is accepted no earlier than the cycle after the FIN2 handshake.
// - Reset mid-operation: immediate return to IDLE; partial stream is not resumed.
// - Latency: header accept to task_start = 3 cycles with no stalls.
// - Latency: done handshake to first cmd_out_tvalid = 1 cycle.
// CONFIGURATION
// - ACC_CYCLE_COUNT_EN defined:
//   - 32-bit counter: cleared at task_start, increments each RUN cycle, saturates at 2**32-1.
//   - FIN3 appended after FIN2, tdata = {32'h0, count}.
//   - FIN0 header byte1 = 8'h01 (extra-word flag).
// - ACC_CYCLE_COUNT_EN undefined: no counter; 3-word finish; FIN0 byte1 = 0.
// TESTING
// - T1: hdr 0x0201, tid 0xA5, ptid 0x7, args 0x11,0x22(tlast), arg_tready=1
//   -> task_start once; arg_tdata 0x11 then 0x22 with arg_tlast on 0x22; task_id=0xA5.
// - T2: T1 then done after 10 cycles, cmd_out_tready toggling 1/0
//   -> words 0x03, 0xA5, 0x7 in order, stable under stall, tid=ACC_ID.
//   - With ACC_CYCLE_COUNT_EN: 4th word = 10.
// - T3: hdr 0x0001, tid, ptid(tlast) -> no arg beats; task_start; RUN.
// - T4: hdr 0x0301, tid, ptid, arg(tlast)
//   -> proto_err; one arg beat with arg_tlast; back to IDLE; no finish.
// - T5: hdr code 0x05 + 3 words, last has tlast -> proto_err; all consumed; IDLE; no task_start.
// - T6: rst asserted in ARGS
//   -> outputs zero immediately; next valid command processes normally.

Source files
------------

// File: rtl/acc_cmd_endpoint_if.sv
// -----------------------------------------------------------------------------
// acc_cmd_endpoint_if
//   Bundles the stream and handshake signals of one accelerator command
//   endpoint. The endpoint itself connects through the "slave" modport. The
//   manager/core side (or a bench standing in for both) uses "master".
//
//   Signal groups:
//     cmd_in_*   manager -> endpoint command words (tvalid/tready/tdata/tlast)
//     arg_*      endpoint -> core task arguments   (tvalid/tready/tdata/tlast)
//     task_*     endpoint -> core task start pulse and current task id
//     done_*     core -> endpoint completion handshake
//     cmd_out_*  endpoint -> manager finish words  (tvalid/tready/tid/tdata)
//     proto_err  endpoint -> system protocol error pulse
//
//   Parameter:
//     ACC_BITS   width of cmd_out_tid
// -----------------------------------------------------------------------------
interface acc_cmd_endpoint_if #(
  parameter int unsigned ACC_BITS = 4
) ();

  logic                cmd_in_tvalid;
  logic                cmd_in_tready;
  logic [63:0]         cmd_in_tdata;
  logic                cmd_in_tlast;

  logic                arg_tvalid;
  logic                arg_tready;
  logic [63:0]         arg_tdata;
  logic                arg_tlast;

  logic                task_start;
  logic [63:0]         task_id;

  logic                done_valid;
  logic                done_ready;

  logic                cmd_out_tvalid;
  logic                cmd_out_tready;
  logic [ACC_BITS-1:0] cmd_out_tid;
  logic [63:0]         cmd_out_tdata;

  logic                proto_err;

  // Endpoint view.
  modport slave (
    input  cmd_in_tvalid, cmd_in_tdata, cmd_in_tlast,
    output cmd_in_tready,
    output arg_tvalid, arg_tdata, arg_tlast,
    input  arg_tready,
    output task_start, task_id,
    input  done_valid,
    output done_ready,
    output cmd_out_tvalid, cmd_out_tid, cmd_out_tdata,
    input  cmd_out_tready,
    output proto_err
  );

  // Manager / core view.
  modport master (
    output cmd_in_tvalid, cmd_in_tdata, cmd_in_tlast,
    input  cmd_in_tready,
    input  arg_tvalid, arg_tdata, arg_tlast,
    output arg_tready,
    input  task_start, task_id,
    output done_valid,
    input  done_ready,
    input  cmd_out_tvalid, cmd_out_tid, cmd_out_tdata,
    output cmd_out_tready,
    input  proto_err
  );

endinterface

// File: rtl/acc_cmd_endpoint.sv
// -----------------------------------------------------------------------------
// acc_cmd_endpoint
//   Accelerator-side endpoint of the manager command protocol.
//   An execute-task command arrives on cmd_in as:
//     W0 header {tdata[7:0]=code (0x01), tdata[15:8]=nargs}
//     W1 task id
//     W2 parent task id
//     nargs argument words, forwarded combinationally to the core on arg_*.
//   tlast marks the final word of a command.
//   After the arguments the endpoint waits for done_valid from the core.
//   It then returns a finish command on cmd_out:
//     {56'h0 | flags<<8, 8'h03}, task id, parent id (and optionally a cycle count)
//   Every finish word is tagged with ACC_ID on cmd_out_tid.
//
//   Malformed commands pulse proto_err:
//     - a bad header code or a missing tlast on the last word drains the rest
//       of the command up to tlast.
//     - an early tlast aborts straight back to IDLE.
//
//   Ports:
//     clk   clock
//     rst   asynchronous reset, active high
//     bus   acc_cmd_endpoint_if.slave (cmd_in, arg, task, done, cmd_out,
//           proto_err)
//
//   Parameters:
//     ACC_BITS   width of accelerator id / cmd_out_tid
//     ACC_ID     this accelerator's id
//     ARG_CNT_W  width of the argument counter
//
//   Build option:
//     ACC_CYCLE_COUNT_EN  when defined, counts RUN cycles (saturating, 32 bit).
//                         The count is appended as a fourth finish word
//                         {32'h0, count], and FIN0 byte1 is set to 8'h01.
// -----------------------------------------------------------------------------
module acc_cmd_endpoint #(
  parameter int unsigned ACC_BITS  = 4,
  parameter int unsigned ACC_ID    = 0,
  parameter int unsigned ARG_CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  acc_cmd_endpoint_if.slave bus
);

  localparam logic [7:0] CODE_EXEC = 8'h01;
  localparam logic [7:0] CODE_FIN  = 8'h03;
`ifdef ACC_CYCLE_COUNT_EN
  localparam logic [7:0] FIN_FLAGS = 8'h01;
`else
  localparam logic [7:0] FIN_FLAGS = 8'h00;
`endif

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_TID   = 4'd1,
    ST_PTID  = 4'd2,
    ST_ARGS  = 4'd3,
    ST_RUN   = 4'd4,
    ST_FIN0  = 4'd5,
    ST_FIN1  = 4'd6,
    ST_FIN2  = 4'd7,
    ST_FIN3  = 4'd8,
    ST_DRAIN = 4'd9
  } state_t;

  state_t               state_r;
  logic [ARG_CNT_W-1:0] nargs_r;
  logic [ARG_CNT_W-1:0] remaining_r;
  logic [63:0]          task_id_r;
  logic [63:0]          parent_r;
  logic                 in_ready_r;    // cmd_in_tready in every state except ARGS
  logic                 done_ready_r;
  logic                 task_start_r;
  logic                 proto_err_r;
  logic                 out_valid_r;
  logic [63:0]          out_data_r;
`ifdef ACC_CYCLE_COUNT_EN
  logic [31:0]          run_cnt_r;
`endif

  logic                 in_args_s;
  logic                 in_ready_s;
  logic                 in_hs_s;
  logic                 done_hs_s;
  logic                 out_hs_s;
  logic                 arg_last_s;
  logic [7:0]           hdr_code_s;
  logic [ARG_CNT_W-1:0] hdr_nargs_s;

  // In ARGS the input stream is wired straight through to the core, so
  // readiness comes from the core. Elsewhere a registered flag is used.
  // That flag is 0 in reset and in RUN/FIN.
  assign in_args_s   = (state_r == ST_ARGS);
  assign in_ready_s  = in_args_s ? bus.arg_tready : in_ready_r;
  assign in_hs_s     = bus.cmd_in_tvalid & in_ready_s;
  assign done_hs_s   = bus.done_valid & done_ready_r;
  assign out_hs_s    = out_valid_r & bus.cmd_out_tready;
  assign arg_last_s  = (remaining_r == ARG_CNT_W'(1));
  assign hdr_code_s  = bus.cmd_in_tdata[7:0];
  assign hdr_nargs_s = ARG_CNT_W'(bus.cmd_in_tdata[15:8]);

  assign bus.cmd_in_tready  = in_ready_s;
  assign bus.arg_tvalid     = in_args_s & bus.cmd_in_tvalid;
  assign bus.arg_tdata      = in_args_s ? bus.cmd_in_tdata : 64'h0;
  // An early tlast still closes the argument packet towards the core.
  assign bus.arg_tlast      = in_args_s & (arg_last_s | bus.cmd_in_tlast);
  assign bus.task_start     = task_start_r;
  assign bus.task_id        = task_id_r;
  assign bus.done_ready     = done_ready_r;
  assign bus.cmd_out_tvalid = out_valid_r;
  assign bus.cmd_out_tdata  = out_data_r;
  assign bus.cmd_out_tid    = ACC_BITS'(ACC_ID);
  assign bus.proto_err      = proto_err_r;

  // Command FSM. All control outputs and the finish word are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      nargs_r      <= '0;
      remaining_r  <= '0;
      task_id_r    <= 64'h0;
      parent_r     <= 64'h0;
      in_ready_r   <= 1'b0;
      done_ready_r <= 1'b0;
      task_start_r <= 1'b0;
      proto_err_r  <= 1'b0;
      out_valid_r  <= 1'b0;
      out_data_r   <= 64'h0;
`ifdef ACC_CYCLE_COUNT_EN
      run_cnt_r    <= 32'h0;
`endif
    end else begin
      task_start_r <= 1'b0;
      proto_err_r  <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          // Also raises readiness on the first cycle after reset.
          in_ready_r <= 1'b1;
          if (in_hs_s) begin
            if ((hdr_code_s == CODE_EXEC) && !bus.cmd_in_tlast) begin
              nargs_r <= hdr_nargs_s;
              state_r <= ST_TID;
            end else begin
              // Bad code, or a one-word command: drain the rest unless this
              // word already ended the command.
              proto_err_r <= 1'b1;
              state_r     <= bus.cmd_in_tlast ? ST_IDLE : ST_DRAIN;
            end
          end
        end

        ST_TID: begin
          if (in_hs_s) begin
            if (bus.cmd_in_tlast) begin
              proto_err_r <= 1'b1;
              state_r     <= ST_IDLE;
            end else begin
              task_id_r <= bus.cmd_in_tdata;
              state_r   <= ST_PTID;
            end
          end
        end

        ST_PTID: begin
          if (in_hs_s) begin
            if (nargs_r == ARG_CNT_W'(0)) begin
              if (bus.cmd_in_tlast) begin
                parent_r     <= bus.cmd_in_tdata;
                task_start_r <= 1'b1;
                done_ready_r <= 1'b1;
                in_ready_r   <= 1'b0;
                state_r      <= ST_RUN;
`ifdef ACC_CYCLE_COUNT_EN
                run_cnt_r    <= 32'h0;
`endif
              end else begin
                // Argument-less task carries extra words.
                proto_err_r <= 1'b1;
                state_r     <= ST_DRAIN;
              end
            end else if (bus.cmd_in_tlast) begin
              proto_err_r <= 1'b1;
              state_r     <= ST_IDLE;
            end else begin
              parent_r     <= bus.cmd_in_tdata;
              task_start_r <= 1'b1;
              remaining_r  <= nargs_r;
              in_ready_r   <= 1'b0;
              state_r      <= ST_ARGS;
`ifdef ACC_CYCLE_COUNT_EN
              run_cnt_r    <= 32'h0;
`endif
            end
          end
        end

        ST_ARGS: begin
          if (in_hs_s) begin
            remaining_r <= remaining_r - ARG_CNT_W'(1);
            if (arg_last_s) begin
              if (bus.cmd_in_tlast) begin
                done_ready_r <= 1'b1;
                state_r      <= ST_RUN;
              end else begin
                proto_err_r <= 1'b1;
                in_ready_r  <= 1'b1;
                state_r     <= ST_DRAIN;
              end
            end else if (bus.cmd_in_tlast) begin
              proto_err_r <= 1'b1;
              in_ready_r  <= 1'b1;
              state_r     <= ST_IDLE;
            end else begin
              state_r <= ST_ARGS;
            end
          end
        end

        ST_RUN: begin
`ifdef ACC_CYCLE_COUNT_EN
          if (run_cnt_r != 32'hFFFF_FFFF) begin
            run_cnt_r <= run_cnt_r + 32'h1;
          end
`endif
          if (done_hs_s) begin
            done_ready_r <= 1'b0;
            out_valid_r  <= 1'b1;
            out_data_r   <= {48'h0, FIN_FLAGS, CODE_FIN};
            state_r      <= ST_FIN0;
          end
        end

        // Each FIN state loads the next word only on a handshake, so
        // tdata/tvalid hold steady while the manager stalls.
        ST_FIN0: begin
          if (out_hs_s) begin
            out_data_r <= task_id_r;
            state_r    <= ST_FIN1;
          end
        end

        ST_FIN1: begin
          if (out_hs_s) begin
            out_data_r <= parent_r;
            state_r    <= ST_FIN2;
          end
        end

        ST_FIN2: begin
          if (out_hs_s) begin
`ifdef ACC_CYCLE_COUNT_EN
            out_data_r <= {32'h0, run_cnt_r};
            state_r    <= ST_FIN3;
`else
            out_valid_r <= 1'b0;
            out_data_r  <= 64'h0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
`endif
          end
        end

`ifdef ACC_CYCLE_COUNT_EN
        ST_FIN3: begin
          if (out_hs_s) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 64'h0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
`endif

        ST_DRAIN: begin
          if (in_hs_s && bus.cmd_in_tlast) begin
            state_r <= ST_IDLE;
          end
        end

        default: begin
          state_r      <= ST_IDLE;
          in_ready_r   <= 1'b1;
          done_ready_r <= 1'b0;
          out_valid_r  <= 1'b0;
          out_data_r   <= 64'h0;
        end
      endcase
    end
  end

endmodule
